multi_lane_note_judge: RTL and testbench
========================================

MULTI_LANE_NOTE_JUDGE -- requirements
Module: multi_lane_note_judge

Interface
REQ-001 SHALL have parameter LANES, default 5, number of note columns (1..8).
REQ-002 SHALL have parameter POS_W, default 10, note Y-position width in bits.
REQ-003 SHALL have parameter DIV, default 17, Clk cycles per frame tick (DIV >= 2).
REQ-004 SHALL have parameter HIT_LO, default 10'h1A0, first Y inside the hit window (inclusive).
REQ-005 SHALL have parameter HIT_HI, default 10'h1C0, last Y inside the hit window (inclusive); HIT_HI < MISS_Y.
REQ-006 SHALL have parameter MISS_Y, default 10'h1E0, Y at or beyond which a falling note is missed.
REQ-007 SHALL have parameter FLASH, default 4, number of frame ticks the HIT/MISS state is held.
REQ-008 SHALL have port Clk, input, 1, system clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high.
REQ-010 SHALL have port noteStart, input, LANES, per-lane launch request, level-sampled every Clk.
REQ-011 SHALL have port fret, input, LANES, per-lane fret held (active-high).
REQ-012 SHALL have port strum, input, 1, strum level (active-high); the block edge-detects it.
REQ-013 SHALL have port M, input, POS_W, Y increment per frame tick.
REQ-014 SHALL have port frameTick, output, 1, one-Clk pulse per frame.
REQ-015 SHALL have port noteY, output, LANES*POS_W, lane l's Y in bits [l*POS_W +: POS_W].
REQ-016 SHALL have port laneState, output, 2*LANES, lane l's state in bits [2l+1:2l]: 00 IDLE, 01 FALL, 10 HIT, 11 MISS.
REQ-017 SHALL have ports hitPulse and missPulse, output, LANES each, one-Clk per-lane event pulses.
REQ-018 SHALL have ports score (output, 16, hit count) and streak (output, 8, consecutive hits).

Function
REQ-019 SHALL count frame ticks with a modulo-DIV counter; frameTick high exactly when the counter equals DIV-1, so the first tick occurs DIV cycles after reset release.
REQ-020 SHALL treat a strum event as strum high this cycle and low the previous cycle (one event per press).
REQ-021 Lane in IDLE with noteStart[l]=1 SHALL enter FALL next cycle with Y=0; noteStart in any other state SHALL be ignored.
REQ-022 In FALL, on frameTick, Y SHALL become min(Y+M, MISS_Y), computed at POS_W+1 bits (no wrap).
REQ-023 In FALL, a strum event with fret[l]=1 and HIT_LO <= Y <= HIT_HI (current Y) SHALL move the lane to HIT, pulse hitPulse[l], and take priority over the same-cycle frameTick Y update.
REQ-024 In FALL with Y >= MISS_Y SHALL move the lane to MISS next cycle and pulse missPulse[l].
REQ-025 HIT and MISS SHALL each persist for exactly FLASH frame ticks (per-lane tick counter), hold Y frozen, then return to IDLE with Y=0.
REQ-026 Each hitPulse bit SHALL add 1 to score (multiple same-cycle hits add the popcount) saturating at 16'hFFFF, and add the same to streak saturating at 8'hFF.
REQ-027 Any missPulse bit, or a strum event that produces no hit in any lane, SHALL clear streak to 0; a clear in the same cycle as hits SHALL win (streak=0).
REQ-028 Lanes SHALL operate independently; M=0 SHALL freeze FALL notes (no miss).

Reset
REQ-029 reset=1 SHALL on the next edge set all lanes IDLE, noteY=0, frameTick=0, hitPulse=0, missPulse=0, score=0, streak=0, tick divider=0, strum edge history=0, overriding all other inputs including mid-FALL/HIT/MISS.

Verification
REQ-030 Defaults, M=16, noteStart[0] pulse, no strum -> Y reaches 0x1E0 after 30 ticks, missPulse[0] one cycle, MISS 4 ticks, IDLE, score=0.
REQ-031 M=16, fret[2]=1, strum edge when lane 2 Y=0x1B0 -> hitPulse[2], laneState HIT, score=1, streak=1, Y frozen 0x1B0.
REQ-032 Lanes 0 and 1 both at Y=0x1A0, fret=2'b11, one strum edge -> both hitPulses same cycle, score+=2, streak+=2.
REQ-033 Strum edge with fret[0]=1 but lane 0 Y=0x100 and streak=5 -> no hit, streak=0, score unchanged.
REQ-034 Strum held high 50 cycles across window -> at most one hit per press.
REQ-035 reset asserted while lanes in FALL/HIT with score=7 -> next cycle all IDLE, all outputs 0; noteStart launches normally afterward.

Source files
------------

// File: rtl/multi_lane_note_judge.sv
// Multi-lane falling-note judge: frame divider, per-lane note FSMs with hit window,
// strum edge detection, and saturating score/streak bookkeeping.
//
// state  | meaning
// S_IDLE | lane empty, waiting for noteStart
// S_FALL | note falling, Y advances by M each frame tick
// S_HIT  | note judged hit, Y frozen for FLASH ticks
// S_MISS | note reached MISS_Y, Y frozen for FLASH ticks
module multi_lane_note_judge #(
    parameter int              LANES  = 5,
    parameter int              POS_W  = 10,
    parameter int              DIV    = 17,
    parameter logic [POS_W-1:0] HIT_LO = 10'h1A0,
    parameter logic [POS_W-1:0] HIT_HI = 10'h1C0,
    parameter logic [POS_W-1:0] MISS_Y = 10'h1E0,
    parameter int              FLASH  = 4
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       noteStart,
    input  logic [LANES-1:0]       fret,
    input  logic                   strum,
    input  logic [POS_W-1:0]       M,
    output logic                   frameTick,
    output logic [LANES*POS_W-1:0] noteY,
    output logic [2*LANES-1:0]     laneState,
    output logic [LANES-1:0]       hitPulse,
    output logic [LANES-1:0]       missPulse,
    output logic [15:0]            score,
    output logic [7:0]             streak
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FLASH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FALL = 2'b01,
        S_HIT  = 2'b10,
        S_MISS = 2'b11
    } lane_state_t;

    lane_state_t      r_state [LANES];
    logic [POS_W-1:0] r_y     [LANES];
    logic [CNT_W-1:0] r_flash [LANES];
    logic [DIV_W-1:0] r_div;
    logic             r_strum_d;
    logic [LANES-1:0] r_hit;
    logic [LANES-1:0] r_miss;
    logic [15:0]      r_score;
    logic [7:0]       r_streak;

    logic             w_tick;
    logic             w_strum_ev;
    logic [LANES-1:0] w_hit;
    logic [LANES-1:0] w_miss;
    logic [3:0]       w_nhits;
    logic             w_clear;
    logic [16:0]      w_score_sum;
    logic [8:0]       w_streak_sum;
    logic [POS_W:0]   w_y_sum  [LANES];
    logic [POS_W-1:0] w_next_y [LANES];

    assign w_tick     = (r_div == DIV_W'(DIV - 1));
    assign w_strum_ev = strum & ~r_strum_d;

    always_comb begin
        w_nhits = '0;
        w_hit   = '0;
        w_miss  = '0;
        for (int l = 0; l < LANES; l++) begin
            // Extra bit keeps Y+M from wrapping before the clamp to MISS_Y.
            w_y_sum[l]  = {1'b0, r_y[l]} + {1'b0, M};
            w_next_y[l] = (w_y_sum[l] >= {1'b0, MISS_Y}) ? MISS_Y : w_y_sum[l][POS_W-1:0];
            w_hit[l]    = (r_state[l] == S_FALL) && w_strum_ev && fret[l] &&
                          (r_y[l] >= HIT_LO) && (r_y[l] <= HIT_HI);
            w_miss[l]   = (r_state[l] == S_FALL) && (r_y[l] >= MISS_Y);
            w_nhits     = w_nhits + 4'(w_hit[l]);
        end
    end

    assign w_clear      = (|w_miss) | (w_strum_ev & ~(|w_hit));
    assign w_score_sum  = {1'b0, r_score} + 17'(w_nhits);
    assign w_streak_sum = {1'b0, r_streak} + 9'(w_nhits);

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_div     <= '0;
            r_strum_d <= 1'b0;
            r_hit     <= '0;
            r_miss    <= '0;
            r_score   <= '0;
            r_streak  <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_state[l] <= S_IDLE;
                r_y[l]     <= '0;
                r_flash[l] <= '0;
            end
        end else begin
            r_div     <= w_tick ? '0 : r_div + 1'b1;
            r_strum_d <= strum;
            r_hit     <= w_hit;
            r_miss    <= w_miss;
            r_score   <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            if (w_clear)
                r_streak <= '0;
            else
                r_streak <= w_streak_sum[8] ? 8'hFF : w_streak_sum[7:0];

            for (int l = 0; l < LANES; l++) begin
                case (r_state[l])
                    S_IDLE: begin
                        if (noteStart[l]) begin
                            r_state[l] <= S_FALL;
                            r_y[l]     <= '0;
                        end
                    end
                    S_FALL: begin
                        r_flash[l] <= '0;
                        if (w_hit[l])
                            r_state[l] <= S_HIT;
                        else if (w_miss[l])
                            r_state[l] <= S_MISS;
                        else if (w_tick)
                            r_y[l] <= w_next_y[l];
                    end
                    S_HIT, S_MISS: begin
                        if (w_tick) begin
                            if (r_flash[l] == CNT_W'(FLASH - 1)) begin
                                r_state[l] <= S_IDLE;
                                r_y[l]     <= '0;
                                r_flash[l] <= '0;
                            end else begin
                                r_flash[l] <= r_flash[l] + 1'b1;
                            end
                        end
                    end
                    default: r_state[l] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        noteY     = '0;
        laneState = '0;
        for (int l = 0; l < LANES; l++) begin
            noteY[l*POS_W +: POS_W] = r_y[l];
            laneState[2*l +: 2]     = r_state[l];
        end
    end

    assign frameTick = w_tick;
    assign hitPulse  = r_hit;
    assign missPulse = r_miss;
    assign score     = r_score;
    assign streak    = r_streak;

endmodule

// File: tb/tb_multi_lane_note_judge.sv
// Directed bench for multi_lane_note_judge: miss path, hits at window edges,
// double hit, failed strum, held strum, reset override and M=0 freeze.
module tb_multi_lane_note_judge;

    logic        Clk = 1'b0;
    logic        reset;
    logic [4:0]  noteStart;
    logic [4:0]  fret;
    logic        strum;
    logic [9:0]  M;
    logic        frameTick;
    logic [49:0] noteY;
    logic [9:0]  laneState;
    logic [4:0]  hitPulse;
    logic [4:0]  missPulse;
    logic [15:0] score;
    logic [7:0]  streak;

    int n_checks = 0;
    int n_err    = 0;
    int hitcount;

    multi_lane_note_judge dut (
        .Clk(Clk), .reset(reset), .noteStart(noteStart), .fret(fret), .strum(strum),
        .M(M), .frameTick(frameTick), .noteY(noteY), .laneState(laneState),
        .hitPulse(hitPulse), .missPulse(missPulse), .score(score), .streak(streak)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ly(input int l);
        return noteY[l*10 +: 10];
    endfunction

    function automatic logic [1:0] ls(input int l);
        return laneState[2*l +: 2];
    endfunction

    task automatic step();
        @(negedge Clk);
    endtask

    // Advance until the cycle after the next frame tick has been applied.
    task automatic wait_tick();
        int n = 0;
        while (frameTick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("tick_timeout", 32'(n), 32'd0);
        step();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) wait_tick();
    endtask

    task automatic launch(input logic [4:0] mask);
        noteStart = mask;
        step();
        noteStart = '0;
    endtask

    initial begin
        reset = 1'b1; noteStart = '0; fret = '0; strum = 1'b0; M = 10'd16;
        step(); step();
        reset = 1'b0;
        chk("rst_state", 32'(laneState), 32'd0);
        chk("rst_y", 32'(noteY[31:0]), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_tick", 32'(frameTick), 32'd0);

        // first frame tick after DIV-1 counter increments
        repeat (15) step();
        chk("tick_early", 32'(frameTick), 32'd0);
        step();
        chk("tick_first", 32'(frameTick), 32'd1);
        step();
        chk("tick_single", 32'(frameTick), 32'd0);

        // note falls through to MISS
        launch(5'b00001);
        chk("l0_fall", 32'(ls(0)), 32'd1);
        chk("l0_y0", 32'(ly(0)), 32'd0);
        ticks(29);
        chk("l0_y29", 32'(ly(0)), 32'h1D0);
        ticks(1);
        chk("l0_y30", 32'(ly(0)), 32'h1E0);
        chk("l0_still_fall", 32'(ls(0)), 32'd1);
        step();
        chk("l0_miss", 32'(ls(0)), 32'd3);
        chk("l0_misspulse", 32'(missPulse), 32'b00001);
        step();
        chk("l0_misspulse_end", 32'(missPulse), 32'd0);
        ticks(3);
        chk("l0_miss_hold", 32'(ls(0)), 32'd3);
        chk("l0_miss_y", 32'(ly(0)), 32'h1E0);
        ticks(1);
        chk("l0_idle", 32'(ls(0)), 32'd0);
        chk("l0_idle_y", 32'(ly(0)), 32'd0);
        chk("miss_score", 32'(score), 32'd0);

        // single hit mid-window
        launch(5'b00100);
        fret = 5'b00100;
        ticks(27);
        chk("l2_y", 32'(ly(2)), 32'h1B0);
        strum = 1'b1;
        step();
        chk("l2_hitpulse", 32'(hitPulse), 32'b00100);
        chk("l2_hit", 32'(ls(2)), 32'd2);
        chk("l2_score", 32'(score), 32'd1);
        chk("l2_streak", 32'(streak), 32'd1);
        strum = 1'b0;
        step();
        chk("l2_hitpulse_end", 32'(hitPulse), 32'd0);
        ticks(3);
        chk("l2_hit_hold", 32'(ls(2)), 32'd2);
        chk("l2_frozen", 32'(ly(2)), 32'h1B0);
        ticks(1);
        chk("l2_idle", 32'(ls(2)), 32'd0);

        // double hit at HIT_LO
        launch(5'b00011);
        fret = 5'b00011;
        ticks(26);
        chk("l01_y", 32'(ly(1)), 32'h1A0);
        strum = 1'b1;
        step();
        chk("dbl_hitpulse", 32'(hitPulse), 32'b00011);
        chk("dbl_score", 32'(score), 32'd3);
        chk("dbl_streak", 32'(streak), 32'd3);
        strum = 1'b0;
        ticks(4);
        chk("dbl_idle", 32'(laneState), 32'd0);

        // double hit at HIT_HI
        launch(5'b11000);
        fret = 5'b11000;
        ticks(28);
        chk("l34_y", 32'(ly(4)), 32'h1C0);
        strum = 1'b1;
        step();
        chk("hi_hitpulse", 32'(hitPulse), 32'b11000);
        chk("hi_score", 32'(score), 32'd5);
        chk("hi_streak", 32'(streak), 32'd5);
        strum = 1'b0;
        ticks(4);

        // strum outside window clears streak
        launch(5'b00001);
        fret = 5'b00001;
        ticks(16);
        chk("l0_y100", 32'(ly(0)), 32'h100);
        strum = 1'b1;
        step();
        chk("nohit_pulse", 32'(hitPulse), 32'd0);
        chk("nohit_streak", 32'(streak), 32'd0);
        chk("nohit_score", 32'(score), 32'd5);
        chk("nohit_fall", 32'(ls(0)), 32'd1);
        strum = 1'b0;
        step();

        // strum held across the window yields no hit; a fresh press does
        ticks(8);
        chk("l0_y180", 32'(ly(0)), 32'h180);
        strum = 1'b1;
        hitcount = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            hitcount += int'(hitPulse[0]);
        end
        chk("held_hits", 32'(hitcount), 32'd0);
        chk("held_y", 32'(ly(0)), 32'h1A0);
        strum = 1'b0;
        step();
        strum = 1'b1;
        step();
        chk("repress_pulse", 32'(hitPulse), 32'b00001);
        chk("repress_y", 32'(ly(0)), 32'h1B0);
        chk("repress_score", 32'(score), 32'd6);
        chk("repress_streak", 32'(streak), 32'd1);
        strum = 1'b0;
        ticks(4);

        // reset overrides mid-HIT/FALL
        launch(5'b00110);
        fret = 5'b00010;
        ticks(26);
        strum = 1'b1;
        step();
        chk("pre_rst_score", 32'(score), 32'd7);
        chk("pre_rst_streak", 32'(streak), 32'd2);
        chk("pre_rst_state", 32'(laneState), 32'b0000011000);
        reset = 1'b1; noteStart = 5'b11111; fret = 5'b11111;
        step();
        chk("rst2_state", 32'(laneState), 32'd0);
        chk("rst2_y", 32'(noteY[49:32]), 32'd0);
        chk("rst2_y_lo", 32'(noteY[31:0]), 32'd0);
        chk("rst2_score", 32'(score), 32'd0);
        chk("rst2_streak", 32'(streak), 32'd0);
        chk("rst2_pulses", 32'({hitPulse, missPulse}), 32'd0);
        reset = 1'b0; noteStart = '0; strum = 1'b0; fret = '0;
        M = 10'd0;
        launch(5'b10000);
        chk("post_rst_launch", 32'(laneState), 32'b0100000000);
        ticks(3);
        chk("m0_frozen_y", 32'(ly(4)), 32'd0);
        chk("m0_still_fall", 32'(ls(4)), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
